// File: rtl/alu_shift_left_seq_if.sv
// Handshake and result bundle for the sequential left shifter.
// The master side issues start/A/AMT. The slave side (the shifter) returns
// busy/done/Z/zero.
interface alu_shift_left_seq_if #(
   parameter int unsigned N  = 32,
   parameter int unsigned SW = 5
);
   logic          start;
   logic [N-1:0]  A;
   logic [SW-1:0] AMT;
   logic          busy;
   logic          done;
   logic [N-1:0]  Z;
   logic          zero;

   modport master (
      output start, A, AMT,
      input  busy, done, Z, zero
   );

   modport slave (
      input  start, A, AMT,
      output busy, done, Z, zero
   );
endinterface

// File: rtl/alu_shift_left_seq.sv
// Multi-cycle logical left shifter for the ALU datapath.
// Each step moves R left by 4 bits while at least 4 bits of shift remain, and
// by 1 bit otherwise. The result is published to Z/zero together with a
// one-cycle done pulse on the edge that leaves the DONE state.
// Optional build macro ALU_SHL_ROTATE_EN: every step rotates instead of shifting.
module alu_shift_left_seq #(
   parameter int unsigned N  = 32,
   parameter int unsigned SW = 5
) (
   input logic                clk,
   input logic                rstb,
   alu_shift_left_seq_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  r_q, r_d;
   logic [SW-1:0] count_q, count_d;
   logic [N-1:0]  z_q, z_d;
   logic          zero_q, zero_d;
   logic          done_q, done_d;

   logic [N-1:0]  step4;
   logic [N-1:0]  step1;

   // Candidate single-step updates of R
   always_comb begin
`ifdef ALU_SHL_ROTATE_EN
      step4 = {r_q[N-5:0], r_q[N-1:N-4]};
      step1 = {r_q[N-2:0], r_q[N-1]};
`else
      step4 = r_q << 4;
      step1 = r_q << 1;
`endif
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      count_d = count_q;
      z_d     = z_q;
      zero_d  = zero_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               r_d     = bus.A;
               count_d = bus.AMT;
               state_d = (bus.AMT != '0) ? StShift : StDone;
            end
         end
         StShift: begin
            // Compare at 32 bits so narrow SW cannot truncate the constant
            if (32'(count_q) >= 32'd4) begin
               r_d     = step4;
               count_d = count_q - SW'(4);
            end else begin
               r_d     = step1;
               count_d = count_q - SW'(1);
            end
            state_d = (count_d == '0) ? StDone : StShift;
         end
         StDone: begin
            z_d     = r_q;
            zero_d  = (r_q == '0);
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and result registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= StIdle;
         r_q     <= '0;
         count_q <= '0;
         z_q     <= '0;
         zero_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         count_q <= count_d;
         z_q     <= z_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q != StIdle);
   assign bus.done = done_q;
   assign bus.Z    = z_q;
   assign bus.zero = zero_q;

endmodule

// File: tb/tb_alu_shift_left_seq.sv
// Self-checking bench for alu_shift_left_seq (N=32, SW=5).
// Directed scenarios plus randomized operations against a plain-arithmetic model.
module tb_alu_shift_left_seq;

   localparam int unsigned N  = 32;
   localparam int unsigned SW = 5;

   logic clk;
   logic rstb;
   int   n_vec;
   int   n_err;

   alu_shift_left_seq_if #(.N(N), .SW(SW)) bus_if ();

   alu_shift_left_seq #(.N(N), .SW(SW)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected result: logical shift by amt, or rotate by amt mod N
   function automatic logic [31:0] ref_result(input logic [31:0] a, input int amt);
      logic [63:0] t;
`ifdef ALU_SHL_ROTATE_EN
      t = {a, a} << (amt % 32);
      return t[63:32];
`else
      t = {32'h0, a} << amt;
      return t[31:0];
`endif
   endfunction

   // Edges from accept to the done pulse
   function automatic int ref_latency(input int amt);
      return amt / 4 + amt % 4 + 1;
   endfunction

   // Issue one op; optionally pulse a second request while busy
   task automatic do_op(input string tag, input logic [31:0] a, input int amt,
                        input logic [31:0] exp_z, input bit poke);
      int lat;
      int busy_cnt;
      @(negedge clk);
      check_eq({tag, ".idle"}, 64'(bus_if.busy), 64'd0);
      bus_if.start = 1'b1;
      bus_if.A     = a;
      bus_if.AMT   = SW'(amt);
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      while (bus_if.done !== 1'b1 && lat < 200) begin
         if (bus_if.busy === 1'b1) busy_cnt++;
         if (poke && lat < 2) begin
            bus_if.start = 1'b1;
            bus_if.A     = 32'h1;
            bus_if.AMT   = SW'(1);
         end else begin
            bus_if.start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      bus_if.start = 1'b0;
      check_eq({tag, ".lat"},  64'(lat), 64'(ref_latency(amt)));
      check_eq({tag, ".busyc"}, 64'(busy_cnt), 64'(ref_latency(amt)));
      check_eq({tag, ".z"},    64'(bus_if.Z), 64'(exp_z));
      check_eq({tag, ".zero"}, 64'(bus_if.zero), 64'(exp_z == 32'h0));
      check_eq({tag, ".busy"}, 64'(bus_if.busy), 64'd0);
      @(posedge clk);
      #1;
      check_eq({tag, ".pulse"}, 64'(bus_if.done), 64'd0);
      check_eq({tag, ".hold"},  64'(bus_if.Z), 64'(exp_z));
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (bus_if.done !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      logic [31:0] ra;
      int          ramt;
      int          lat;
      bit          saw_done;
      n_vec = 0;
      n_err = 0;
      rstb         = 1'b0;
      bus_if.start = 1'b0;
      bus_if.A     = '0;
      bus_if.AMT   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.busy", 64'(bus_if.busy), 64'd0);
      check_eq("rst.done", 64'(bus_if.done), 64'd0);
      check_eq("rst.z",    64'(bus_if.Z),    64'd0);
      check_eq("rst.zero", 64'(bus_if.zero), 64'd1);
      @(negedge clk);
      rstb = 1'b1;

      do_op("t1", 32'h0000_00F1, 6,  32'h0000_3C40, 1'b0);
      do_op("t2", 32'h0000_0001, 31, 32'h8000_0000, 1'b0);
      do_op("t3", 32'h1234_5678, 0,  32'h1234_5678, 1'b0);
`ifdef ALU_SHL_ROTATE_EN
      do_op("t4", 32'h8000_0001, 4,  32'h0000_0018, 1'b0);
`else
      do_op("t4", 32'h8000_0001, 4,  32'h0000_0010, 1'b0);
`endif
      do_op("t5", 32'hFFFF_FFFF, 8,  32'hFFFF_FF00, 1'b1);
      do_op("t5b", 32'h0000_0001, 1, 32'h0000_0002, 1'b0);
      do_op("zero", 32'h0000_0000, 5, 32'h0000_0000, 1'b0);

      // Reset during SHIFT
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.A     = 32'h1;
      bus_if.AMT   = SW'(20);
      @(negedge clk);
      bus_if.start = 1'b0;
      @(negedge clk);
      rstb = 1'b0;
      @(posedge clk);
      #1;
      check_eq("t6.busy", 64'(bus_if.busy), 64'd0);
      check_eq("t6.done", 64'(bus_if.done), 64'd0);
      check_eq("t6.z",    64'(bus_if.Z),    64'd0);
      check_eq("t6.zero", 64'(bus_if.zero), 64'd1);
      @(negedge clk);
      rstb = 1'b1;
      saw_done = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) saw_done = 1'b1;
      end
      check_eq("t6.quiet", 64'(saw_done), 64'd0);
      do_op("t6b", 32'h0000_000F, 4, 32'h0000_00F0, 1'b0);

      // Start held high: next op accepted on the first IDLE edge after done
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.A     = 32'h3;
      bus_if.AMT   = SW'(2);
      wait_done(lat);
      check_eq("b2b.lat1", 64'(lat), 64'(ref_latency(2) + 1));
      @(posedge clk);
      #1;
      check_eq("b2b.accept", 64'(bus_if.busy), 64'd1);
      bus_if.start = 1'b0;
      wait_done(lat);
      check_eq("b2b.lat2", 64'(lat), 64'(ref_latency(2)));
      check_eq("b2b.z",    64'(bus_if.Z), 64'(ref_result(32'h3, 2)));
      @(posedge clk);
      #1;

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         ra   = $urandom;
         ramt = int'($urandom_range(0, 31));
         if (i % 8 == 0) ra = 32'h0;
         do_op("rand", ra, ramt, ref_result(ra, ramt), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
